// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over req/gnt/rvalid,
// buffers {pc,instr} in a 2-entry FIFO and flushes on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_next;
  logic [31:0] addr_q;
  logic [31:0] target;
  logic        drop;
  logic        drop_next;
  logic [1:0]  count;
  logic [1:0]  count_next;
  logic        rd_ptr;
  logic        wr_ptr;
  logic        push;
  logic        pop;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];

  assign target      = redirect_pc & 32'hFFFF_FFFC;
  assign imem_req    = (state == REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (count != 2'd0);
  assign instr       = instr_valid ? buf_instr[rd_ptr] : NOP_INSTR;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr] : 32'h0;

  // FIFO traffic, occupancy and next fetch PC
  always_comb begin
    pop  = instr_valid & instr_ready & ~redirect_valid;
    push = (state == WAIT) & imem_rvalid & ~drop & ~redirect_valid;
    count_next = count + {1'b0, push} - {1'b0, pop};
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      count_next    = 2'd0;
      fetch_pc_next = target;
    end else if (push) begin
      fetch_pc_next = fetch_pc + 32'd4;
    end
  end

  // Fetch FSM next state and drop tracking
  always_comb begin
    state_next = state;
    drop_next  = drop;
    unique case (state)
      IDLE: begin
        if (count_next < 2'd2) state_next = REQ;
      end
      REQ: begin
        if (redirect_valid) drop_next = 1'b1;
        if (imem_gnt) state_next = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_next  = 1'b0;
          state_next = (count_next < 2'd2) ? REQ : IDLE;
        end else if (redirect_valid) begin
          drop_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state; the request address freezes while REQ is pending
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      addr_q   <= RESET_PC;
      drop     <= 1'b0;
      count    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      drop     <= drop_next;
      count    <= count_next;
      if (state != REQ) addr_q <= fetch_pc_next;
      if (redirect_valid) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  // FIFO storage; contents only read when the entry is valid
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr]    <= fetch_pc;
      buf_instr[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random memory/consumer behaviour,
// scoreboard of the expected program-order instruction stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] mem_fn(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // expected stream: consecutive words from the restart address
  task automatic restart(logic [31:0] a);
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < 2000; k++) begin
      e.pc  = a + 32'(4 * k);
      e.ins = mem_fn(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // ---------------- memory model ----------------
  int          gnt_pct   = 100;
  int          lat_min   = 1;
  int          lat_max   = 1;
  bit          gnt_block = 0;
  int          lat_cnt   = 0;
  logic [31:0] pend_addr;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend_addr   = 32'h0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_fn(pend_addr);
        end
      end
      imem_gnt = imem_req && !gnt_block &&
                 (int'($urandom_range(99)) < gnt_pct);
      if (imem_gnt) begin
        pend_addr = imem_addr;
        lat_cnt   = int'($urandom_range(lat_max, lat_min));
      end
    end
  end

  // ---------------- monitor ----------------
  int          pops      = 0;
  int          grants    = 0;
  int          rel_cyc   = 0;
  int          first_req = -1;
  int          first_val = -1;
  bit          inflight  = 0;
  bit          stale     = 0;
  bit          resp;
  bit          hold_req  = 0;
  bit          hold_val  = 0;
  logic [31:0] exp_addr  = RESET_PC;
  logic [31:0] prev_addr;
  logic [31:0] prev_pc;
  logic [31:0] prev_ins;
  exp_t        e;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      resp = imem_rvalid && inflight;
      if (imem_rvalid) inflight = 0;
      if (!reset_n) begin
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_pc", instr_pc, 32'h0);
        exp_addr  = RESET_PC;
        stale     = 0;
        hold_req  = 0;
        hold_val  = 0;
        rel_cyc   = 0;
        first_req = -1;
        first_val = -1;
      end else begin
        if (first_req < 0 && imem_req) first_req = rel_cyc;
        if (first_val < 0 && instr_valid) first_val = rel_cyc;
        rel_cyc++;
        if (hold_req) begin
          chk("req_held", 32'(imem_req), 32'h1);
          chk("addr_held", imem_addr, prev_addr);
        end
        if (hold_val) begin
          chk("valid_held", 32'(instr_valid), 32'h1);
          chk("pc_held", instr_pc, prev_pc);
          chk("instr_held", instr, prev_ins);
        end
        if (!instr_valid) begin
          chk("empty_instr", instr, NOP_INSTR);
          chk("empty_pc", instr_pc, 32'h0);
        end else if (instr_ready && !redirect_valid) begin
          pops++;
          if (exp_q.size() == 0) begin
            chk("pop_unexpected", instr_pc, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", instr_pc, e.pc);
            chk("pop_instr", instr, e.ins);
          end
        end
        if (resp && !redirect_valid) begin
          if (stale) stale = 0;
          else exp_addr = exp_addr + 32'd4;
        end
        if (imem_req && imem_gnt) begin
          grants++;
          chk("one_outstanding", 32'(inflight), 32'h0);
          chk("addr_align", 32'(imem_addr[1:0]), 32'h0);
          if (!stale) chk("fetch_addr", imem_addr, exp_addr);
          inflight = 1;
        end
        if (redirect_valid) begin
          exp_addr = redirect_pc & 32'hFFFF_FFFC;
          stale    = !resp && (inflight || imem_req);
        end
        hold_req  = imem_req && !imem_gnt;
        prev_addr = imem_addr;
        hold_val  = instr_valid && !instr_ready && !redirect_valid;
        prev_pc   = instr_pc;
        prev_ins  = instr;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic redirect(logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    restart(t & 32'hFFFF_FFFC);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  task automatic wait_cond(string n, bit want_req);
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (want_req ? imem_req : inflight) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk(n, 32'h0, 32'h1);
  endtask

  int          p0;
  int          g0;
  logic [31:0] held;

  initial begin
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b1;
    restart(RESET_PC);
    repeat (3) @(negedge clk);

    // 1: full-speed fetch from reset
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t1_first_req", 32'(first_req), 32'd1);
    chk("t1_req_to_valid", 32'(first_val - first_req), 32'd2);
    p0 = pops;
    repeat (20) @(negedge clk);
    chk("t1_throughput", 32'(pops - p0), 32'd10);

    // 2: consumer stalls, FIFO fills with pc 0 and 4
    instr_ready = 1'b0;
    reset_n     = 1'b0;
    restart(RESET_PC);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    g0      = grants;
    repeat (10) @(negedge clk);
    chk("t2_grants", 32'(grants - g0), 32'd2);
    chk("t2_req_low", 32'(imem_req), 32'h0);
    chk("t2_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    repeat (20) @(negedge clk);

    // 3: redirect while waiting for data
    lat_min = 3;
    lat_max = 3;
    wait_cond("t3_wait_timeout", 1'b0);
    redirect(32'h0000_0103);
    repeat (20) @(negedge clk);

    // 4: redirect while request is stuck without grant
    lat_min   = 1;
    lat_max   = 1;
    gnt_block = 1;
    wait_cond("t4_req_timeout", 1'b1);
    held = imem_addr;
    redirect(32'h0000_2000);
    repeat (2) @(negedge clk);
    chk("t4_addr_held", imem_addr, held);
    gnt_block = 0;
    repeat (20) @(negedge clk);

    // 5: wrap at top of address space, slow memory
    lat_min = 5;
    lat_max = 5;
    redirect(32'hFFFF_FFFC);
    p0 = pops;
    repeat (40) @(negedge clk);
    chk("t5_progress", 32'(pops - p0 >= 3), 32'h1);

    // 6: reset during an outstanding read
    lat_min = 4;
    lat_max = 4;
    wait_cond("t6_wait_timeout", 1'b0);
    reset_n = 1'b0;
    restart(RESET_PC);
    repeat (8) @(negedge clk);
    lat_min = 1;
    lat_max = 1;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t6_first_req", 32'(first_req), 32'd1);
    chk("t6_req_to_valid", 32'(first_val - first_req), 32'd2);

    // random traffic
    gnt_pct = 60;
    lat_max = 4;
    p0      = pops;
    for (int c = 0; c < 2500; c++) begin
      instr_ready = ($urandom_range(3) != 0);
      if ($urandom_range(39) == 0) redirect($urandom);
      else @(negedge clk);
    end
    instr_ready = 1'b1;
    gnt_pct     = 100;
    repeat (30) @(negedge clk);
    chk("rand_progress", 32'(pops - p0 >= 300), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
